// File: rtl/starwars_sysctl.sv
// -----------------------------------------------------------------------------
// starwars_sysctl
//
// Main-CPU system controller for the Star Wars arcade core.
// Decodes CPU writes in the 0x4640-0x469F region and provides:
//   - the periodic 6809 IRQ, with its IRQCLR clear (0x4660 region)
//   - the main-CPU watchdog, reloaded by WDCLR (0x4640 region)
//   - the 8-bit miscellaneous output latch (0x4680 region), bit-addressed
//     by main_cpu_address[2:0] and written from main_cpu_data_out[7]
// Address bits [4:3] are don't-care throughout, so each register aliases
// four times inside its 32-byte region.
//
// Build option:
//   SYSCTL_WATCHDOG_EN - when defined, the watchdog counter and its RUN/FIRE
//   state machine are built. When undefined, wdog_reset is tied to 0 and
//   WDCLR writes are decoded and ignored.
//
// Parameters:
//   IRQ_PERIOD  - clk_12 cycles between IRQ assertions
//   WDOG_PERIOD - clk_12 cycles without a WDCLR before the watchdog fires
//   WDOG_PULSE  - width of wdog_reset in clk_12 cycles
//
// Ports:
//   clk_12            in   1  the only clock
//   reset             in   1  synchronous, active-high
//   main_cpu_address  in  16  CPU address bus
//   main_cpu_data_out in   8  CPU write data
//   main_cpu_RnW      in   1  1 = read, 0 = write
//   cpu_wr_strobe     in   1  one-cycle write qualifier
//   irq_n             out  1  active-low IRQ to the main CPU
//   wdog_reset        out  1  active-high reset request to the main CPU
//   coin_cntr2 .. recall out 1 each: output latch bits 0..7
// -----------------------------------------------------------------------------
module starwars_sysctl #(
   parameter int IRQ_PERIOD  = 49152,
   parameter int WDOG_PERIOD = 196608,
   parameter int WDOG_PULSE  = 16
) (
   input  logic        clk_12,
   input  logic        reset,
   input  logic [15:0] main_cpu_address,
   input  logic [7:0]  main_cpu_data_out,
   input  logic        main_cpu_RnW,
   input  logic        cpu_wr_strobe,
   output logic        irq_n,
   output logic        wdog_reset,
   output logic        coin_cntr2,
   output logic        coin_cntr1,
   output logic        led3,
   output logic        led2,
   output logic        mpage,
   output logic        prngclr,
   output logic        led1,
   output logic        recall
);

   localparam logic [10:0] REGION_WDCLR  = 11'b01000110010;  // 0x4640
   localparam logic [10:0] REGION_IRQCLR = 11'b01000110011;  // 0x4660
   localparam logic [10:0] REGION_LATCH  = 11'b01000110100;  // 0x4680

   localparam int IRQ_W = (IRQ_PERIOD > 1) ? $clog2(IRQ_PERIOD) : 1;
   localparam logic [IRQ_W-1:0] IRQ_LAST = IRQ_W'(IRQ_PERIOD - 1);

   // ---------------------------------------------------------------- decode
   logic wr;
   logic wr_wdclr;
   logic wr_irqclr;
   logic wr_latch;

   assign wr        = cpu_wr_strobe & ~main_cpu_RnW;
   assign wr_wdclr  = wr & (main_cpu_address[15:5] == REGION_WDCLR);
   assign wr_irqclr = wr & (main_cpu_address[15:5] == REGION_IRQCLR);
   assign wr_latch  = wr & (main_cpu_address[15:5] == REGION_LATCH);

   // Address bits [4:3] and data bits [6:0] are intentionally don't-care.
   logic unused_bits;
   assign unused_bits = ^{main_cpu_address[4:3], main_cpu_data_out[6:0]};

   // ---------------------------------------------------------- output latch
   logic [7:0] latch_q;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk_12) begin
      if (reset) begin
         latch_q <= '0;
      end else if (wr_latch) begin
         latch_q[main_cpu_address[2:0]] <= main_cpu_data_out[7];
      end
   end

   assign coin_cntr2 = latch_q[0];
   assign coin_cntr1 = latch_q[1];
   assign led3       = latch_q[2];
   assign led2       = latch_q[3];
   assign mpage      = latch_q[4];
   assign prngclr    = latch_q[5];
   assign led1       = latch_q[6];
   assign recall     = latch_q[7];

   // ------------------------------------------------------------- IRQ timer
   // The pending flag is stored directly in its active-low form so irq_n is
   // a flop output. Terminal count is checked before IRQCLR so a coincident
   // clear loses to the new IRQ.
   logic [IRQ_W-1:0] irq_cnt;
   logic             irq_tc;
   logic             irq_n_q;

   assign irq_tc = (irq_cnt == IRQ_LAST);

   always_ff @(posedge clk_12) begin
      if (reset) begin
         irq_cnt <= '0;
         irq_n_q <= 1'b1;
      end else begin
         irq_cnt <= irq_tc ? '0 : irq_cnt + 1'b1;
         if (irq_tc) begin
            irq_n_q <= 1'b0;
         end else if (wr_irqclr) begin
            irq_n_q <= 1'b1;
         end
      end
   end

   assign irq_n = irq_n_q;

   // -------------------------------------------------------------- watchdog
`ifdef SYSCTL_WATCHDOG_EN
   localparam int WD_W = (WDOG_PERIOD > 1) ? $clog2(WDOG_PERIOD) : 1;
   localparam int WP_W = (WDOG_PULSE > 1) ? $clog2(WDOG_PULSE) : 1;
   localparam logic [WD_W-1:0] WD_LAST    = WD_W'(WDOG_PERIOD - 1);
   localparam logic [WP_W-1:0] PULSE_LAST = WP_W'(WDOG_PULSE - 1);

   typedef enum logic {
      WD_RUN  = 1'b0,
      WD_FIRE = 1'b1
   } wd_state_t;

   wd_state_t       wd_state, wd_state_nxt;
   logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
   logic [WP_W-1:0] pulse_cnt, pulse_cnt_nxt;
   logic            wdog_reset_q;

   always_ff @(posedge clk_12) begin
      if (reset) begin
         wd_state     <= WD_RUN;
         wd_cnt       <= '0;
         pulse_cnt    <= '0;
         wdog_reset_q <= 1'b0;
      end else begin
         wd_state     <= wd_state_nxt;
         wd_cnt       <= wd_cnt_nxt;
         pulse_cnt    <= pulse_cnt_nxt;
         wdog_reset_q <= (wd_state_nxt == WD_FIRE);
      end
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      wd_state_nxt  = wd_state;
      wd_cnt_nxt    = wd_cnt;
      pulse_cnt_nxt = pulse_cnt;
      case (wd_state)
         WD_RUN: begin
            // WDCLR takes priority over a coincident terminal count.
            if (wr_wdclr) begin
               wd_cnt_nxt = '0;
            end else if (wd_cnt == WD_LAST) begin
               wd_state_nxt  = WD_FIRE;
               wd_cnt_nxt    = '0;
               pulse_cnt_nxt = '0;
            end else begin
               wd_cnt_nxt = wd_cnt + 1'b1;
            end
         end
         WD_FIRE: begin
            // WDCLR is ignored while the pulse is being driven.
            if (pulse_cnt == PULSE_LAST) begin
               wd_state_nxt  = WD_RUN;
               pulse_cnt_nxt = '0;
            end else begin
               pulse_cnt_nxt = pulse_cnt + 1'b1;
            end
         end
         default: begin
            wd_state_nxt  = WD_RUN;
            wd_cnt_nxt    = '0;
            pulse_cnt_nxt = '0;
         end
      endcase
   end

   assign wdog_reset = wdog_reset_q;
`else
   // Watchdog not built: WDCLR is still decoded but has no effect.
   localparam int unused_wdog_cfg = WDOG_PERIOD + WDOG_PULSE;
   logic unused_wdclr;
   assign unused_wdclr = wr_wdclr;
   assign wdog_reset   = 1'b0;
`endif

endmodule

// File: tb/tb_starwars_sysctl.sv
// -----------------------------------------------------------------------------
// tb_starwars_sysctl
//
// Directed self-checking bench for starwars_sysctl with IRQ_PERIOD = 8,
// WDOG_PERIOD = 32 and WDOG_PULSE = 4. Inputs change 1 time unit after the
// rising edge and outputs are sampled at that same point, so each cycle()
// call advances exactly one clock edge. Watchdog-timing steps are compiled
// only when SYSCTL_WATCHDOG_EN is defined; otherwise wdog_reset is expected
// to stay 0 throughout.
// -----------------------------------------------------------------------------
module tb_starwars_sysctl;

   logic        clk_12 = 1'b0;
   logic        reset;
   logic [15:0] main_cpu_address;
   logic [7:0]  main_cpu_data_out;
   logic        main_cpu_RnW;
   logic        cpu_wr_strobe;
   logic        irq_n;
   logic        wdog_reset;
   logic        coin_cntr2, coin_cntr1, led3, led2;
   logic        mpage, prngclr, led1, recall;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef SYSCTL_WATCHDOG_EN
   localparam logic WD_BUILT = 1'b1;
`else
   localparam logic WD_BUILT = 1'b0;
`endif

   starwars_sysctl #(
      .IRQ_PERIOD (8),
      .WDOG_PERIOD(32),
      .WDOG_PULSE (4)
   ) dut (
      .clk_12           (clk_12),
      .reset            (reset),
      .main_cpu_address (main_cpu_address),
      .main_cpu_data_out(main_cpu_data_out),
      .main_cpu_RnW     (main_cpu_RnW),
      .cpu_wr_strobe    (cpu_wr_strobe),
      .irq_n            (irq_n),
      .wdog_reset       (wdog_reset),
      .coin_cntr2       (coin_cntr2),
      .coin_cntr1       (coin_cntr1),
      .led3             (led3),
      .led2             (led2),
      .mpage            (mpage),
      .prngclr          (prngclr),
      .led1             (led1),
      .recall           (recall)
   );

   always #5 clk_12 = ~clk_12;

   // Latch outputs gathered in bit order 7..0.
   logic [7:0] latch_obs;
   assign latch_obs = {recall, led1, prngclr, mpage, led2, led3, coin_cntr1, coin_cntr2};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk_12);
      #1;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
      main_cpu_address  = addr;
      main_cpu_data_out = data;
      main_cpu_RnW      = 1'b0;
      cpu_wr_strobe     = 1'b1;
      cycle();
      cpu_wr_strobe     = 1'b0;
      main_cpu_RnW      = 1'b1;
   endtask

   task automatic bus_read(input logic [15:0] addr);
      main_cpu_address  = addr;
      main_cpu_data_out = 8'h80;
      main_cpu_RnW      = 1'b1;
      cpu_wr_strobe     = 1'b1;
      cycle();
      cpu_wr_strobe     = 1'b0;
   endtask

   // Hold reset for one edge; on return reset is released and the edge
   // count since deassertion is 0.
   task automatic do_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      logic seen;
      reset             = 1'b1;
      main_cpu_address  = 16'h0000;
      main_cpu_data_out = 8'h00;
      main_cpu_RnW      = 1'b1;
      cpu_wr_strobe     = 1'b0;
      cycle();

      // ---- reset state
      do_reset();
      check("reset_irq_n", irq_n, 1'b1);
      check("reset_wdog", wdog_reset, 1'b0);
      check("reset_latch", latch_obs, 8'h00);

      // ---- IRQ timing (edges counted from reset release)
      cycles(7);
      check("irq_before_tc", irq_n, 1'b1);
      cycle();                                   // edge 8: terminal count
      check("irq_first_fall", irq_n, 1'b0);
      bus_write(16'h467F, 8'h00);                // edge 9: IRQCLR via alias
      check("irqclr_raises", irq_n, 1'b1);
      cycles(6);                                 // edges 10..15
      check("irq_idle_after_clr", irq_n, 1'b1);
      bus_write(16'h4660, 8'h00);                // edge 16: IRQCLR on terminal count
      check("irqclr_vs_tc", irq_n, 1'b0);

      // ---- output latch
      bus_write(16'h4684, 8'h80);
      check("latch_mpage_set", latch_obs, 8'h10);
      check("mpage_bit", mpage, 1'b1);
      bus_write(16'h4686, 8'h00);
      check("latch_led1_clear", latch_obs, 8'h10);
      bus_write(16'h4684, 8'h7F);
      check("latch_mpage_clear", latch_obs, 8'h00);
      bus_write(16'h469F, 8'h80);
      check("latch_alias_recall", latch_obs, 8'h80);
      bus_read(16'h4681);
      check("latch_read_no_effect", latch_obs, 8'h80);
      bus_write(16'h46A1, 8'h80);
      check("latch_outside_region", latch_obs, 8'h80);
      bus_write(16'h4640, 8'hFF);
      check("latch_wdclr_no_effect", latch_obs, 8'h80);
      bus_write(16'h4689, 8'hFF);
      check("latch_alias_coin1", latch_obs, 8'h82);
      check("irq_unaffected_by_latch", irq_n, 1'b0);

`ifdef SYSCTL_WATCHDOG_EN
      // ---- watchdog: no WDCLR
      do_reset();
      cycles(31);
      check("wd_before_fire", wdog_reset, 1'b0);
      cycle();                                   // edge 32
      check("wd_fire_rise", wdog_reset, 1'b1);
      cycles(3);                                 // edges 33..35
      check("wd_fire_hold", wdog_reset, 1'b1);
      cycle();                                   // edge 36
      check("wd_fire_end", wdog_reset, 1'b0);
      check("wd_keeps_latch", latch_obs, 8'h00);

      // ---- watchdog: WDCLR every 20 cycles
      do_reset();
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 19; i++) begin
            cycle();
            if (wdog_reset !== 1'b0) seen = 1'b1;
         end
         bus_write(16'h4648, 8'h00);
         if (wdog_reset !== 1'b0) seen = 1'b1;
      end
      check("wd_serviced_quiet", seen, 1'b0);

      // ---- WDCLR coincident with terminal count, then WDCLR during FIRE
      do_reset();
      cycles(31);
      bus_write(16'h4640, 8'h00);                // edge 32: WDCLR wins
      check("wdclr_vs_tc", wdog_reset, 1'b0);
      cycles(31);
      check("wd_after_clr_quiet", wdog_reset, 1'b0);
      cycle();
      check("wd_fire_after_clr", wdog_reset, 1'b1);
      bus_write(16'h4640, 8'h00);                // ignored during FIRE
      check("wdclr_in_fire", wdog_reset, 1'b1);
      cycles(2);
      check("wd_fire_last", wdog_reset, 1'b1);
      cycle();
      check("wd_fire_done", wdog_reset, 1'b0);
`endif

      // ---- reset mid-operation: latch full, IRQ pending, FIRE (if built)
      do_reset();
      for (int b = 0; b < 8; b++) begin
         bus_write(16'h4680 | 16'(b), 8'h80);    // edges 1..8
      end
      cycles(24);                                // edges 9..32
      check("pre_reset_latch", latch_obs, 8'hFF);
      check("pre_reset_irq", irq_n, 1'b0);
      check("pre_reset_wdog", wdog_reset, WD_BUILT);
      reset = 1'b1;
      cycle();
      check("midreset_latch", latch_obs, 8'h00);
      check("midreset_irq", irq_n, 1'b1);
      check("midreset_wdog", wdog_reset, 1'b0);
      reset = 1'b0;

`ifndef SYSCTL_WATCHDOG_EN
      // ---- watchdog not built: 1000 cycles without WDCLR
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         cycle();
         if (wdog_reset !== 1'b0) seen = 1'b1;
      end
      check("no_wd_build_quiet", seen, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/starwars_sysctl.md
# starwars_sysctl

Main-CPU system controller for the Star Wars arcade core. Decodes CPU writes in the 0x4640–0x469F region. Generates the periodic 6809 IRQ and its clear, and runs the watchdog that resets the main CPU. Holds the 8-bit miscellaneous output latch: coin counters, LEDs, MPAGE, PRNGCLR and RECALL. Sits beside the ALU, sound and vector boards on the shared main-CPU bus, in the clk_12 domain.

## Interface

Parameters:
- IRQ_PERIOD, 49152: clk_12 cycles between IRQ assertions (4.096 ms).
- WDOG_PERIOD, 196608: clk_12 cycles without a WDCLR write before a watchdog reset fires.
- WDOG_PULSE, 16: width of wdog_reset in clk_12 cycles.

Ports:
- clk_12, input, 1: the only clock.
- reset, input, 1: synchronous, active-high.
- main_cpu_address, input, 16: CPU address bus.
- main_cpu_data_out, input, 8: CPU write data.
- main_cpu_RnW, input, 1: 1 = read, 0 = write.
- cpu_wr_strobe, input, 1: one-cycle qualifier; at most one per CPU bus cycle.
- irq_n, output, 1: active-low IRQ to the main CPU.
- wdog_reset, output, 1: active-high reset request to the main CPU.
- coin_cntr2, coin_cntr1, led3, led2, mpage, prngclr, led1, recall: outputs, 1 each; latch bits 0..7.

## Operation

- A write is `wr = cpu_wr_strobe & !main_cpu_RnW`. The region is selected by main_cpu_address[15:5]. Address bits [4:3] are ignored everywhere.
- 0x4640 region ([15:5] = 01000110010), WDCLR: reloads the watchdog counter. Data is ignored.
- 0x4660 region ([15:5] = 01000110011), IRQCLR: clears the IRQ pending flag. Data is ignored.
- 0x4680 region ([15:5] = 01000110100), output latch:
  - main_cpu_address[2:0] selects the latch bit: 0 coin_cntr2, 1 coin_cntr1, 2 led3, 3 led2, 4 mpage, 5 prngclr, 6 led1, 7 recall.
  - The selected bit takes main_cpu_data_out[7]. The other bits hold.
- Reads and writes outside these regions have no effect.
- IRQ timer:
  - Free-running counter, 0..IRQ_PERIOD-1, that wraps to 0.
  - At terminal count it sets pending. irq_n = !pending.
  - IRQCLR does not reset the counter.
- Watchdog:
  - States are RUN and FIRE.
  - RUN: the counter increments each cycle. At WDOG_PERIOD-1 it goes to FIRE and the counter clears.
  - FIRE: wdog_reset = 1 for WDOG_PULSE cycles, then back to RUN with the counter at 0.
  - WDCLR writes during FIRE are ignored.
- Counter widths are $clog2 of the respective parameter. No overflow beyond the terminal count.

## Timing

- On reset:
  - irq_n = 1, pending = 0.
  - wdog_reset = 0, watchdog state RUN, counter 0.
  - IRQ counter 0.
  - All eight latch outputs 0.
- All outputs are registered.
- Latch, IRQCLR and WDCLR effects are visible the cycle after the write strobe.
- irq_n falls the cycle after the IRQ counter reaches IRQ_PERIOD-1. The first IRQ falls IRQ_PERIOD cycles after reset deasserts.
- IRQCLR and the IRQ terminal count in the same cycle: pending stays 1 (the new IRQ wins).
- WDCLR and the watchdog terminal count in the same cycle: WDCLR wins; stay in RUN with the counter at 0.
- wdog_reset rises the cycle after the watchdog terminal count. It stays high exactly WDOG_PULSE cycles.
- wdog_reset does not reset this block: the latch and IRQ state persist. Only `reset` clears them.
- `reset` mid-pulse aborts FIRE immediately; wdog_reset is 0 the next cycle.

## Configuration

- SYSCTL_WATCHDOG_EN
  - Defined: watchdog built as described.
  - Undefined: no watchdog counter or state machine; wdog_reset tied to 0; WDCLR writes decoded and ignored.
- Latch and IRQ behaviour are identical in both builds.

## Test plan

- Latch write: write 0x80 to 0x4684, then 0x00 to 0x4686. Required: mpage = 1 and led1 = 0; other latch outputs stay 0. Then 0x7F to 0x4684 gives mpage = 0.
- Alias and read: write 0x80 to 0x469F, which drives recall = 1. A read cycle (main_cpu_RnW = 1) at 0x4681 leaves coin_cntr1 = 0.
- IRQ, with IRQ_PERIOD = 8:
  - irq_n low 8 cycles after reset.
  - IRQCLR write raises it next cycle.
  - IRQCLR coincident with terminal count leaves irq_n low.
- Watchdog, with WDOG_PERIOD = 32 and WDOG_PULSE = 4:
  - No WDCLR: wdog_reset high for exactly 4 cycles, starting 32 cycles after reset.
  - WDCLR every 20 cycles: wdog_reset never asserts.
- Reset mid-operation:
  - Assert reset during the FIRE pulse with latch = 0xFF and irq_n = 0.
  - Next cycle all outputs are at reset values.
- Build without SYSCTL_WATCHDOG_EN: run 1000 cycles with no WDCLR; wdog_reset stays 0.
